// File: rtl/sclib_tmr_hs_rx_pkg.sv
// Shared definitions for the TMR 4-phase handshake receiver:
// one-hot FSM encodings and the 3-input majority voter.
package sclib_tmr_hs_rx_pkg;

   localparam int ST_W = 6;

   typedef enum logic [ST_W-1:0] {
      ST_IDLE  = 6'b000001,
      ST_SETTL = 6'b000010,
      ST_CAPT  = 6'b000100,
      ST_HOLD  = 6'b001000,
      ST_ACKW  = 6'b010000,
      ST_RECOV = 6'b100000
   } hs_state_e;

   function automatic logic [ST_W-1:0] maj3_st(input logic [ST_W-1:0] a,
                                                input logic [ST_W-1:0] b,
                                                input logic [ST_W-1:0] c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/sclib_tmr_syncff.sv
// Triplicated multi-stage synchronizer; the output is the bitwise vote of the
// last stage of three independent chains.
module sclib_tmr_syncff #(
   parameter int SYNCC    = 2,
   parameter bit SET1RST0 = 1'b0
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   (* dont_touch = "true" *) logic [SYNCC-1:0] r_ch0;
   (* dont_touch = "true" *) logic [SYNCC-1:0] r_ch1;
   (* dont_touch = "true" *) logic [SYNCC-1:0] r_ch2;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ch0 <= {SYNCC{SET1RST0}};
         r_ch1 <= {SYNCC{SET1RST0}};
         r_ch2 <= {SYNCC{SET1RST0}};
      end else begin
         r_ch0 <= {r_ch0[SYNCC-2:0], i_d};
         r_ch1 <= {r_ch1[SYNCC-2:0], i_d};
         r_ch2 <= {r_ch2[SYNCC-2:0], i_d};
      end
   end

   assign o_q = (r_ch0[SYNCC-1] & r_ch1[SYNCC-1]) |
                (r_ch0[SYNCC-1] & r_ch2[SYNCC-1]) |
                (r_ch1[SYNCC-1] & r_ch2[SYNCC-1]);

endmodule

// File: rtl/sclib_tmr_hs_rx.sv
// Receive side of a 4-phase REQ/ACK handshake from an asynchronous sender, with
// triplicated self-scrubbing FSM and data capture, presented on a valid/ready port.
module sclib_tmr_hs_rx
   import sclib_tmr_hs_rx_pkg::*;
#(
   parameter int SYNCC  = 2,
   parameter int DW     = 8,
   parameter int SETTLE = 1,
   parameter int TOUT   = 255
) (
   input  logic            CLK,
   input  logic            SRB,
   input  logic            REQ,
   input  logic [DW-1:0]   DIN,
   output logic            ACK,
   output logic [DW-1:0]   DOUT,
   output logic            DVALID,
   input  logic            DREADY,
   output logic            BUSY,
   output logic            TOUT_ERR,
   output logic            PROTO_ERR,
   output logic [ST_W-1:0] DBG_STATE
);

   localparam int TW = (TOUT > 0) ? $clog2(TOUT + 1) : 1;
   localparam int FW = $clog2(SYNCC + 1);
   localparam logic [TW-1:0] TMAX     = TW'(TOUT);
   localparam logic [3:0]    CNT_INIT = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

   logic w_req_s;

   (* dont_touch = "true" *) hs_state_e r_st0;
   (* dont_touch = "true" *) hs_state_e r_st1;
   (* dont_touch = "true" *) hs_state_e r_st2;
   (* dont_touch = "true" *) logic [DW-1:0] r_dout0;
   (* dont_touch = "true" *) logic [DW-1:0] r_dout1;
   (* dont_touch = "true" *) logic [DW-1:0] r_dout2;

   hs_state_e     w_st_vote;
   hs_state_e     w_st_nxt;
   logic          w_load;
   logic          w_perr;
   logic          w_terr;
   logic          w_fill_done;
   logic [TW-1:0] w_tmr_inc;

   logic          r_armed;
   logic [FW-1:0] r_fill;
   logic [3:0]    r_cnt;
   logic [TW-1:0] r_tmr;
   logic          r_ack;
   logic          r_dvalid;
   logic          r_busy;
   logic          r_terr;
   logic          r_perr;

   sclib_tmr_syncff #(.SYNCC(SYNCC), .SET1RST0(1'b0)) u_req_sync (
      .i_clk   (CLK),
      .i_rst_n (SRB),
      .i_d     (REQ),
      .o_q     (w_req_s)
   );

   assign w_st_vote   = hs_state_e'(maj3_st(r_st0, r_st1, r_st2));
   // The reset value of the synchronizer is not a real observation of REQ, so
   // arming waits until the chain has been refilled from the pin.
   assign w_fill_done = (r_fill == FW'(SYNCC));
   assign w_tmr_inc   = (&r_tmr) ? r_tmr : r_tmr + 1'b1;

   always_comb begin
      w_st_nxt = w_st_vote;
      w_load   = 1'b0;
      w_perr   = 1'b0;
      w_terr   = 1'b0;
      case (w_st_vote)
         ST_IDLE:  if (r_armed && w_req_s) w_st_nxt = (SETTLE == 0) ? ST_CAPT : ST_SETTL;
         ST_SETTL: begin
            if (!w_req_s) begin
               w_st_nxt = ST_IDLE;
               w_perr   = 1'b1;
            end else if (r_cnt == 4'd0) begin
               w_st_nxt = ST_CAPT;
            end
         end
         ST_CAPT: begin
            if (!w_req_s) begin
               w_st_nxt = ST_IDLE;
               w_perr   = 1'b1;
            end else begin
               w_st_nxt = ST_HOLD;
               w_load   = 1'b1;
            end
         end
         // A sender abort wins over a simultaneous consumer accept.
         ST_HOLD: begin
            if (!w_req_s) begin
               w_st_nxt = ST_IDLE;
               w_perr   = 1'b1;
            end else if (DREADY) begin
               w_st_nxt = ST_ACKW;
            end
         end
         ST_ACKW: begin
            if (!w_req_s) begin
               w_st_nxt = ST_IDLE;
            end else if ((TOUT > 0) && (w_tmr_inc >= TMAX)) begin
               w_st_nxt = ST_RECOV;
               w_terr   = 1'b1;
            end
         end
         ST_RECOV: if (!w_req_s) w_st_nxt = ST_IDLE;
         default:  w_st_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge SRB) begin
      if (!SRB) begin
         r_st0    <= ST_IDLE;
         r_st1    <= ST_IDLE;
         r_st2    <= ST_IDLE;
         r_armed  <= 1'b0;
         r_fill   <= '0;
         r_cnt    <= 4'd0;
         r_tmr    <= '0;
         r_dout0  <= '0;
         r_dout1  <= '0;
         r_dout2  <= '0;
         r_ack    <= 1'b0;
         r_dvalid <= 1'b0;
         r_busy   <= 1'b0;
         r_terr   <= 1'b0;
         r_perr   <= 1'b0;
      end else begin
         // Every copy reloads from the vote, so a single upset copy heals in one cycle.
         r_st0 <= w_st_nxt;
         r_st1 <= w_st_nxt;
         r_st2 <= w_st_nxt;
         if (!w_fill_done) r_fill <= r_fill + 1'b1;
         if (!w_req_s && ((w_st_vote == ST_IDLE && w_fill_done) || w_st_vote == ST_RECOV))
            r_armed <= 1'b1;
         else if (w_terr)
            r_armed <= 1'b0;
         if (w_st_nxt == ST_SETTL && w_st_vote != ST_SETTL)
            r_cnt <= CNT_INIT;
         else if (w_st_vote == ST_SETTL && r_cnt != 4'd0)
            r_cnt <= r_cnt - 4'd1;
         r_tmr <= (w_st_vote == ST_ACKW) ? w_tmr_inc : '0;
         if (w_load) begin
            r_dout0 <= DIN;
            r_dout1 <= DIN;
            r_dout2 <= DIN;
         end
         r_ack    <= (w_st_nxt == ST_ACKW);
         r_dvalid <= (w_st_nxt == ST_HOLD);
         r_busy   <= (w_st_nxt != ST_IDLE);
         r_terr   <= w_terr;
         r_perr   <= w_perr;
      end
   end

   assign ACK       = r_ack;
   assign DVALID    = r_dvalid;
   assign BUSY      = r_busy;
   assign TOUT_ERR  = r_terr;
   assign PROTO_ERR = r_perr;
   assign DOUT      = (r_dout0 & r_dout1) | (r_dout0 & r_dout2) | (r_dout1 & r_dout2);
   assign DBG_STATE = w_st_vote;

endmodule

// File: tb/tb_sclib_tmr_hs_rx.sv
// Bench for sclib_tmr_hs_rx: directed handshake scenarios plus a randomized
// sender, all checked every cycle against a transaction-level model.
module tb_sclib_tmr_hs_rx;
  import sclib_tmr_hs_rx_pkg::*;

  localparam int SYNCC  = 2;
  localparam int DW     = 8;
  localparam int SETTLE = 1;
  localparam int TOUT   = 4;

  // clock / reset
  logic            CLK = 1'b0;
  logic            SRB = 1'b0;
  logic            REQ = 1'b0;
  logic [DW-1:0]   DIN = '0;
  logic            DREADY = 1'b0;
  logic            ACK;
  logic [DW-1:0]   DOUT;
  logic            DVALID;
  logic            BUSY;
  logic            TOUT_ERR;
  logic            PROTO_ERR;
  logic [ST_W-1:0] DBG_STATE;

  always #5 CLK = ~CLK;

  sclib_tmr_hs_rx #(.SYNCC(SYNCC), .DW(DW), .SETTLE(SETTLE), .TOUT(TOUT)) dut (
    .CLK(CLK), .SRB(SRB), .REQ(REQ), .DIN(DIN), .ACK(ACK), .DOUT(DOUT),
    .DVALID(DVALID), .DREADY(DREADY), .BUSY(BUSY), .TOUT_ERR(TOUT_ERR),
    .PROTO_ERR(PROTO_ERR), .DBG_STATE(DBG_STATE)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // behavioural model: transaction view of the receiver
  logic [SYNCC-1:0] m_sh;
  int      m_fill, m_age, m_acnt;
  bit      m_armed, m_eng, m_recov, m_ack, m_dvalid, m_terr, m_perr;
  logic [DW-1:0] m_dout;

  task automatic model_reset();
    m_sh = '0; m_fill = 0; m_age = 0; m_acnt = 0;
    m_armed = 0; m_eng = 0; m_recov = 0; m_ack = 0; m_dvalid = 0;
    m_terr = 0; m_perr = 0; m_dout = '0;
  endtask

  task automatic model_step();
    bit rs;
    rs = m_sh[SYNCC-1];
    m_sh = {m_sh[SYNCC-2:0], REQ};
    m_terr = 0;
    m_perr = 0;
    if (m_recov) begin
      if (!rs) begin m_recov = 0; m_armed = 1; end
    end else if (!m_eng) begin
      if (!rs) begin
        if (m_fill >= SYNCC) m_armed = 1;
      end else if (m_armed) begin
        m_eng = 1; m_age = 0;
      end
    end else if (!rs) begin
      // sender let go: clean completion after ACK, otherwise an abort
      m_perr = !m_ack;
      m_eng = 0; m_dvalid = 0; m_ack = 0;
    end else begin
      m_age++;
      if (!m_dvalid && !m_ack && m_age == SETTLE + 1) begin
        m_dout = DIN; m_dvalid = 1;
      end else if (m_dvalid && DREADY) begin
        m_dvalid = 0; m_ack = 1; m_acnt = 0;
      end else if (m_ack) begin
        m_acnt++;
        if (TOUT > 0 && m_acnt == TOUT) begin
          m_ack = 0; m_terr = 1; m_eng = 0; m_recov = 1; m_armed = 0;
        end
      end
    end
    if (m_fill < SYNCC) m_fill++;
  endtask

  initial model_reset();

  always @(posedge CLK) if (SRB) model_step();

  // compare process
  always @(negedge CLK) begin
    chk("ack", 32'(ACK), 32'(m_ack));
    chk("dvalid", 32'(DVALID), 32'(m_dvalid));
    chk("dout", 32'(DOUT), 32'(m_dout));
    chk("busy", 32'(BUSY), 32'(m_eng | m_recov));
    chk("tout_err", 32'(TOUT_ERR), 32'(m_terr));
    chk("proto_err", 32'(PROTO_ERR), 32'(m_perr));
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
    #1;
  endtask

  task automatic finish_xfer();
    DREADY = 1'b1; tick(1);
    REQ = 1'b0; DREADY = 1'b0; tick(4);
  endtask

  int s_wait, s_hold, s_abort, s_age;
  bit s_ack_seen;

  initial begin
    // reset state
    tick(2);
    chk("rst_ack", 32'(ACK), 0);
    chk("rst_dout", 32'(DOUT), 0);
    chk("rst_dvalid", 32'(DVALID), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_errs", 32'({TOUT_ERR, PROTO_ERR}), 0);
    chk("rst_state", 32'(DBG_STATE), 32'(ST_IDLE));
    SRB = 1'b1;
    tick(5);

    // basic transfer, latency SYNCC+SETTLE+2
    REQ = 1'b1; DIN = 8'hA5; DREADY = 1'b1;
    tick(4);
    chk("t1_dvalid_early", 32'(DVALID), 0);
    tick(1);
    chk("t1_dvalid", 32'(DVALID), 1);
    chk("t1_dout", 32'(DOUT), 32'h A5);
    tick(1);
    chk("t1_ack", 32'(ACK), 1);
    REQ = 1'b0; DREADY = 1'b0;
    tick(2);
    chk("t1_ack_hold", 32'(ACK), 1);
    tick(1);
    chk("t1_ack_fall", 32'(ACK), 0);
    chk("t1_busy", 32'(BUSY), 0);
    tick(3);

    // consumer stalls in HOLD
    REQ = 1'b1; DIN = 8'h3C; DREADY = 1'b0;
    tick(5);
    chk("t2_dout", 32'(DOUT), 32'h3C);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("t2_dvalid_held", 32'(DVALID), 1);
      chk("t2_no_ack", 32'(ACK), 0);
    end
    DREADY = 1'b1; tick(1);
    chk("t2_ack", 32'(ACK), 1);
    chk("t2_dvalid_drop", 32'(DVALID), 0);
    REQ = 1'b0; DREADY = 1'b0; tick(4);

    // abort in HOLD, then abort in SETTL keeps 3C
    REQ = 1'b1; DIN = 8'h3C; tick(5);
    REQ = 1'b0; tick(2);
    chk("t4_dvalid_pre", 32'(DVALID), 1);
    tick(1);
    chk("t4_perr", 32'(PROTO_ERR), 1);
    chk("t4_dvalid", 32'(DVALID), 0);
    chk("t4_dout", 32'(DOUT), 32'h3C);
    tick(1);
    chk("t4_perr_pulse", 32'(PROTO_ERR), 0);
    tick(3);
    REQ = 1'b1; DIN = 8'h77; tick(1);
    REQ = 1'b0; tick(3);
    chk("t4b_perr", 32'(PROTO_ERR), 1);
    chk("t4b_dout", 32'(DOUT), 32'h3C);
    tick(3);

    // ACK timeout and recovery
    REQ = 1'b1; DIN = 8'hC3; DREADY = 1'b1;
    tick(6);
    chk("t3_ack", 32'(ACK), 1);
    tick(3);
    chk("t3_ack_still", 32'(ACK), 1);
    tick(1);
    chk("t3_ack_drop", 32'(ACK), 0);
    chk("t3_terr", 32'(TOUT_ERR), 1);
    chk("t3_busy", 32'(BUSY), 1);
    tick(1);
    chk("t3_terr_pulse", 32'(TOUT_ERR), 0);
    tick(6);
    chk("t3_no_capture", 32'(DVALID), 0);
    REQ = 1'b0; DREADY = 1'b0; tick(3);
    chk("t3_idle", 32'(BUSY), 0);
    REQ = 1'b1; DIN = 8'hE7; tick(5);
    chk("t3_recap_dvalid", 32'(DVALID), 1);
    chk("t3_recap_dout", 32'(DOUT), 32'hE7);
    finish_xfer();

    // asynchronous reset in ACKW with REQ high
    REQ = 1'b1; DIN = 8'h99; DREADY = 1'b1; tick(7);
    chk("t5_ack", 32'(ACK), 1);
    #2 SRB = 1'b0; model_reset();
    #1;
    chk("t5_ack0", 32'(ACK), 0);
    chk("t5_dvalid0", 32'(DVALID), 0);
    chk("t5_busy0", 32'(BUSY), 0);
    chk("t5_dout0", 32'(DOUT), 0);
    tick(2);
    SRB = 1'b1;
    tick(12);
    chk("t5_not_armed", 32'(DVALID | BUSY), 0);
    REQ = 1'b0; DREADY = 1'b0; tick(4);
    REQ = 1'b1; DIN = 8'h66; tick(5);
    chk("t5_dvalid", 32'(DVALID), 1);
    chk("t5_dout", 32'(DOUT), 32'h66);
    finish_xfer();

    // single-copy upsets
    force dut.r_dout1 = 8'hFF;
    force dut.r_st2 = ST_ACKW;
    #1;
    chk("t6_dout_vote", 32'(DOUT), 32'h66);
    chk("t6_state_vote", 32'(DBG_STATE), 32'(ST_IDLE));
    #1;
    release dut.r_dout1;
    release dut.r_st2;
    tick(1);
    chk("t6_st2_scrub", 32'(dut.r_st2), 32'(ST_IDLE));
    REQ = 1'b1; DIN = 8'h81; tick(5);
    chk("t6_dout_new", 32'(DOUT), 32'h81);
    finish_xfer();

    // randomized sender and consumer
    s_wait = 2; s_hold = 0; s_abort = 0; s_age = 0; s_ack_seen = 0;
    for (int c = 0; c < 3000; c++) begin
      DREADY = 1'($urandom_range(0, 1));
      if (!REQ) begin
        if (s_wait == 0) begin
          REQ = 1'b1; DIN = 8'($urandom);
          s_ack_seen = 0; s_age = 0;
          s_hold = $urandom_range(0, 7);
          s_abort = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 8) : 0;
        end else s_wait--;
      end else begin
        s_age++;
        if (ACK) s_ack_seen = 1;
        if (s_ack_seen) begin
          if (s_hold == 0) begin REQ = 1'b0; s_wait = $urandom_range(0, 5); end
          else s_hold--;
        end else if (s_abort != 0) begin
          s_abort--;
          if (s_abort == 0) begin REQ = 1'b0; s_wait = $urandom_range(0, 5); end
        end else if (s_age > 40) begin
          REQ = 1'b0; s_wait = $urandom_range(0, 5);
        end
      end
      tick(1);
    end

    REQ = 1'b0; tick(6);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
